router_iact_mc: RTL and testbench

//  Multicast input-activation router: streams a contiguous block of iact words from the iact GLB bank
//  to up to NUM_DEST PE-column scratchpads, with per-destination enable mask and ready backpressure.

---
 rtl/router_pkg.sv | 26 ++
 rtl/router_fifo.sv | 60 ++++++
 rtl/router_iact_mc.sv | 148 ++++++++++++++
 tb/tb_router_iact_mc.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the multicast iact router.
//   - state_e     : controller states (IDLE, RUN, DONE)
//   - GLB_RD_LAT  : iact GLB read latency in cycles (data valid 1 cycle after request)
//   - DEF_*       : default parameter values used by router_iact_mc
//   - count typedefs sized from the default FIFO depth / length width
package router_pkg;

  localparam int DEF_DATA_BITWIDTH     = 16;
  localparam int DEF_ADDR_BITWIDTH_GLB = 10;
  localparam int DEF_LEN_BITWIDTH      = 10;
  localparam int DEF_NUM_DEST          = 3;
  localparam int DEF_FIFO_DEPTH        = 4;

  localparam int GLB_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [$clog2(DEF_FIFO_DEPTH)-1:0] fifo_ptr_t;
  typedef logic [$clog2(DEF_FIFO_DEPTH):0]   fifo_cnt_t;
  typedef logic [DEF_LEN_BITWIDTH-1:0]       len_cnt_t;

endpackage

// File: rtl/router_fifo.sv
// router_fifo: synchronous FIFO, DW bits x DEPTH entries (DEPTH power of 2).
// Ports:
//   clk, rst        clock, asynchronous active-high reset (pointers/count only)
//   push_i          write push_data_i (ignored when full unless popping same cycle)
//   push_data_i     write data
//   pop_i           drop head entry (ignored when empty)
//   head_o          current head entry (stale when empty)
//   count_o         number of stored entries, 0..DEPTH
//   empty_o/full_o  occupancy flags
module router_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DW-1:0]              push_data_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/router_iact_mc.sv
// router_iact_mc: multicast input-activation router. Streams cfg_len words
// starting at cfg_base_addr from the iact GLB to every PE column selected in
// cfg_dest_mask, through a prefetch FIFO that hides the GLB read latency.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   load_spad_ctrl       start pulse, cfg_* sampled on the same edge (ignored while busy)
//   cfg_base_addr/len/dest_mask   transfer configuration
//   read_req_glb_iact, r_addr_glb_iact, r_data_glb_iact   GLB read port
//   w_data_spad          word to scratchpads (FIFO head, holds last value when empty)
//   load_en_spad         per-destination write strobe
//   spad_ready           per-destination ready
//   busy, load_done      status; load_done is a 1-cycle pulse after the last word
//   w_zero_flag          only with IACT_ZERO_FLAG_EN defined: strobe carries a zero word
//   dbg_state            controller state, for observation
// Build option: define IACT_ZERO_FLAG_EN to add the w_zero_flag output.
module router_iact_mc
  import router_pkg::*;
#(
  parameter int DATA_BITWIDTH     = DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH_GLB = DEF_ADDR_BITWIDTH_GLB,
  parameter int LEN_BITWIDTH      = DEF_LEN_BITWIDTH,
  parameter int NUM_DEST          = DEF_NUM_DEST,
  parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_spad_ctrl,
  input  logic [ADDR_BITWIDTH_GLB-1:0] cfg_base_addr,
  input  logic [LEN_BITWIDTH-1:0]      cfg_len,
  input  logic [NUM_DEST-1:0]          cfg_dest_mask,
  output logic                         read_req_glb_iact,
  output logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_iact,
  input  logic [DATA_BITWIDTH-1:0]     r_data_glb_iact,
  output logic [DATA_BITWIDTH-1:0]     w_data_spad,
  output logic [NUM_DEST-1:0]          load_en_spad,
  input  logic [NUM_DEST-1:0]          spad_ready,
  output logic                         busy,
  output logic                         load_done,
`ifdef IACT_ZERO_FLAG_EN
  output logic                         w_zero_flag,
`endif
  output state_e                       dbg_state
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e                       state_q, state_d;
  logic [ADDR_BITWIDTH_GLB-1:0] base_q;
  logic [LEN_BITWIDTH-1:0]      len_q;
  logic [LEN_BITWIDTH-1:0]      issued_q, issued_d;
  logic [LEN_BITWIDTH-1:0]      delivered_q, delivered_d;
  logic [NUM_DEST-1:0]          mask_q;
  logic [GLB_RD_LAT-1:0]        infl_q;
  logic [DATA_BITWIDTH-1:0]     last_q;
  logic [DATA_BITWIDTH-1:0]     fifo_head;
  logic [CNT_W-1:0]             fifo_count;
  logic                         fifo_empty, fifo_full;
  logic                         start_ok, fire;

  assign start_ok = (state_q == IDLE) && load_spad_ctrl;

  // Only request when the FIFO has room for everything already in flight
  // plus this word; the full check is a redundant guard.
  assign read_req_glb_iact = (state_q == RUN) && (issued_q < len_q) && !fifo_full &&
                             ((int'(fifo_count) + $countones(infl_q)) < FIFO_DEPTH);
  assign r_addr_glb_iact   = base_q + ADDR_BITWIDTH_GLB'(issued_q);

  // Scratchpad handshake: a word transfers (fire) when the FIFO holds a word
  // (valid) and every destination in the mask is ready in the same cycle;
  // unselected destinations never stall. All selected columns see the word on
  // one cycle, so a word is either taken by all of them or by none.
  assign fire         = (state_q == RUN) && !fifo_empty && (&(spad_ready | ~mask_q));
  assign load_en_spad = {NUM_DEST{fire}} & mask_q;
  assign w_data_spad  = fifo_empty ? last_q : fifo_head;

`ifdef IACT_ZERO_FLAG_EN
  assign w_zero_flag = fire && (w_data_spad == '0);
`endif

  assign busy      = (state_q != IDLE);
  assign load_done = (state_q == DONE);
  assign dbg_state = state_q;

  router_fifo #(
    .DW    (DATA_BITWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (infl_q[GLB_RD_LAT-1]),
    .push_data_i (r_data_glb_iact),
    .pop_i       (fire),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    case (state_q)
      IDLE: begin
        if (load_spad_ctrl) begin
          state_d     = (cfg_len == '0) ? DONE : RUN;
          issued_d    = '0;
          delivered_d = '0;
        end
      end
      RUN: begin
        if (read_req_glb_iact) issued_d = issued_q + 1'b1;
        if (fire) begin
          delivered_d = delivered_q + 1'b1;
          // Leave on the last fire so load_done follows it by one cycle.
          if (delivered_q == len_q - 1'b1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      delivered_q <= '0;
      base_q      <= '0;
      len_q       <= '0;
      mask_q      <= '0;
      infl_q      <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      // Shift register of outstanding GLB reads; the oldest bit marks data arriving now.
      infl_q      <= GLB_RD_LAT'({infl_q, read_req_glb_iact});
      if (!fifo_empty) last_q <= fifo_head;
      if (start_ok) begin
        base_q <= cfg_base_addr;
        len_q  <= cfg_len;
        mask_q <= cfg_dest_mask;
      end
    end
  end

endmodule

// File: tb/tb_router_iact_mc.sv
// tb_router_iact_mc: randomized self-checking bench for router_iact_mc with a
// transaction-level reference model and directed literal expectations.
// Build option: define IACT_ZERO_FLAG_EN to also exercise w_zero_flag.
module tb_router_iact_mc;
  import router_pkg::*;

  localparam int DW = 16, AW = 10, LW = 10, ND = 3, DEPTH = 4;
  localparam int AMOD = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          load_spad_ctrl;
  logic [AW-1:0] cfg_base_addr;
  logic [LW-1:0] cfg_len;
  logic [ND-1:0] cfg_dest_mask;
  logic          read_req_glb_iact;
  logic [AW-1:0] r_addr_glb_iact;
  logic [DW-1:0] r_data_glb_iact;
  logic [DW-1:0] w_data_spad;
  logic [ND-1:0] load_en_spad;
  logic [ND-1:0] spad_ready;
  logic          busy, load_done;
  state_e        dbg_state;
`ifdef IACT_ZERO_FLAG_EN
  logic          w_zero_flag;
`endif

  router_iact_mc dut (
    .clk               (clk),
    .reset             (reset),
    .load_spad_ctrl    (load_spad_ctrl),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_len           (cfg_len),
    .cfg_dest_mask     (cfg_dest_mask),
    .read_req_glb_iact (read_req_glb_iact),
    .r_addr_glb_iact   (r_addr_glb_iact),
    .r_data_glb_iact   (r_data_glb_iact),
    .w_data_spad       (w_data_spad),
    .load_en_spad      (load_en_spad),
    .spad_ready        (spad_ready),
    .busy              (busy),
    .load_done         (load_done),
`ifdef IACT_ZERO_FLAG_EN
    .w_zero_flag       (w_zero_flag),
`endif
    .dbg_state         (dbg_state)
  );

  // ---------------- counters / check helper ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- GLB memory and responder ----------------
  logic [DW-1:0] glb [AMOD];
  logic          pend_req = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  always @(negedge clk) begin
    pend_req  = read_req_glb_iact;
    pend_addr = r_addr_glb_iact;
  end

  always @(posedge clk) begin
    #1;
    r_data_glb_iact = pend_req ? glb[pend_addr] : DW'($urandom);
  end

  // ---------------- ready driver ----------------
  int            rdy_mode = 0;   // 0 all ready, 1 bit1 toggles, 2 fixed, 3 random
  logic [ND-1:0] rdy_fixed = '1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       spad_ready = '1;
      1:       spad_ready = {1'b1, ~spad_ready[1], 1'b1};
      2:       spad_ready = rdy_fixed;
      default: spad_ready = ND'($urandom);
    endcase
  end

  // ---------------- reference model + scoreboard ----------------
  int            cyc = 0;
  int            m_phase = 0;     // 0 idle, 1 transferring, 2 done pulse
  int            m_base, m_len, m_issued, m_deliv;
  logic [ND-1:0] m_mask;
  logic [DW-1:0] exp_q[$];        // words fetched and waiting for delivery
  bit            m_infl;
  logic [DW-1:0] m_infl_data;
  logic [DW-1:0] m_last = '0;
  int            n_accept = 0;

  logic          e_req, e_fire, all_rdy;
  logic [AW-1:0] e_addr;
  logic [ND-1:0] e_en;
  logic [DW-1:0] e_wd;

  // statistics observed on the DUT pins, per accepted transfer
  int d_fire, d_req, d_throttle, first_fire_cyc, done_cyc, accept_cyc, d_zero, zero_idx;
  int d_done = 0;
  int col_cnt[ND];
  int addr_log[$];
  logic [DW-1:0] data_log[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_busy",  busy, 0);
      chk("rst_req",   read_req_glb_iact, 0);
      chk("rst_en",    load_en_spad, 0);
      chk("rst_done",  load_done, 0);
      chk("rst_wdata", w_data_spad, 0);
      chk("rst_state", dbg_state, IDLE);
      m_phase = 0; m_issued = 0; m_deliv = 0; m_infl = 0; m_last = '0;
      exp_q.delete();
    end else begin
      e_req   = (m_phase == 1) && (m_issued < m_len) && ((exp_q.size() + int'(m_infl)) < DEPTH);
      e_addr  = AW'((m_base + m_issued) % AMOD);
      all_rdy = ((spad_ready | ~m_mask) == '1);
      e_fire  = (m_phase == 1) && (exp_q.size() > 0) && all_rdy;
      e_en    = e_fire ? m_mask : '0;
      e_wd    = (exp_q.size() > 0) ? exp_q[0] : m_last;

      chk("busy",      busy, m_phase != 0);
      chk("load_done", load_done, m_phase == 2);
      chk("read_req",  read_req_glb_iact, e_req);
      if (e_req) chk("r_addr", r_addr_glb_iact, e_addr);
      chk("load_en",   load_en_spad, e_en);
      chk("w_data",    w_data_spad, e_wd);
`ifdef IACT_ZERO_FLAG_EN
      chk("zero_flag", w_zero_flag, e_fire && (e_wd == '0));
      if (w_zero_flag) begin d_zero++; zero_idx = d_fire; end
`endif

      // pin-level statistics
      if (|load_en_spad) begin
        if (d_fire == 0) first_fire_cyc = cyc;
        d_fire++;
        data_log.push_back(w_data_spad);
      end
      for (int i = 0; i < ND; i++) col_cnt[i] += int'(load_en_spad[i]);
      if (read_req_glb_iact) begin d_req++; addr_log.push_back(int'(r_addr_glb_iact)); end
      if (busy && !load_done && !read_req_glb_iact && d_req > 0 && d_req < m_len) d_throttle++;
      if (load_done) begin d_done++; done_cyc = cyc; end

      // advance model by one cycle
      if (exp_q.size() > 0) m_last = exp_q[0];
      if (e_fire) begin void'(exp_q.pop_front()); m_deliv++; end
      if (m_infl) exp_q.push_back(m_infl_data);
      m_infl      = e_req;
      m_infl_data = glb[e_addr];
      if (e_req) m_issued++;
      case (m_phase)
        0: if (load_spad_ctrl) begin
             m_base = int'(cfg_base_addr); m_len = int'(cfg_len); m_mask = cfg_dest_mask;
             m_issued = 0; m_deliv = 0;
             m_phase = (m_len == 0) ? 2 : 1;
             n_accept++; accept_cyc = cyc;
             d_fire = 0; d_req = 0; d_throttle = 0; d_zero = 0; zero_idx = -1;
             for (int i = 0; i < ND; i++) col_cnt[i] = 0;
             addr_log.delete(); data_log.delete();
           end
        1: if (e_fire && m_deliv == m_len) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input int base, input int len, input logic [ND-1:0] mask);
    @(posedge clk); #1;
    load_spad_ctrl = 1'b1;
    cfg_base_addr  = AW'(base);
    cfg_len        = LW'(len);
    cfg_dest_mask  = mask;
    @(posedge clk); #1;
    load_spad_ctrl = 1'b0;
    cfg_base_addr  = AW'($urandom);
    cfg_len        = LW'($urandom);
    cfg_dest_mask  = ND'($urandom);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (!busy && m_phase == 0) break;
    end
    chk({name, "_timeout"}, n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_glb();
    for (int i = 0; i < AMOD; i++) glb[i] = DW'($urandom_range(1, 65535));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  int bad, done_before, acc_before, v;

  initial begin
    reset = 1'b1;
    load_spad_ctrl = 1'b0;
    cfg_base_addr = '0; cfg_len = '0; cfg_dest_mask = '0;
    spad_ready = '1;
    r_data_glb_iact = '0;
    fill_glb();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: base 0, len 25, all columns, always ready
    rdy_mode = 0;
    start_xfer(0, 25, 3'b111);
    wait_idle("t1", 200);
    chk("t1_fires", d_fire, 25);
    for (int i = 0; i < ND; i++) chk("t1_col_cnt", col_cnt[i], 25);
    chk("t1_first_fire_lat", first_fire_cyc - accept_cyc, 3);
    chk("t1_done_lat", done_cyc - accept_cyc, 28);
    bad = 0;
    for (int i = 0; i < 25; i++) if (i >= data_log.size() || data_log[i] !== glb[i]) bad++;
    chk("t1_data_order", bad, 0);

    // 2: same, ready[1] toggles every cycle
    rdy_mode = 1;
    start_xfer(0, 25, 3'b111);
    wait_idle("t2", 300);
    chk("t2_fires", d_fire, 25);
    chk("t2_col1_cnt", col_cnt[1], 25);
    chk("t2_throttled", d_throttle > 0, 1);

    // 3: address wrap, single destination, other readies low
    rdy_mode = 2; rdy_fixed = 3'b010;
    start_xfer(1020, 8, 3'b010);
    wait_idle("t3", 200);
    bad = 0;
    for (int i = 0; i < 8; i++) if (i >= addr_log.size() || addr_log[i] != ((1020 + i) % 1024)) bad++;
    chk("t3_addr_wrap", bad, 0);
    chk("t3_col0", col_cnt[0], 0);
    chk("t3_col1", col_cnt[1], 8);
    chk("t3_col2", col_cnt[2], 0);

    // 4: zero length, then a start while busy
    rdy_mode = 0;
    done_before = d_done;
    start_xfer(7, 0, 3'b111);
    wait_idle("t4a", 20);
    chk("t4_len0_req", d_req, 0);
    chk("t4_len0_done_lat", done_cyc - accept_cyc, 1);
    chk("t4_len0_done_cnt", d_done - done_before, 1);
    acc_before = n_accept;
    start_xfer(100, 20, 3'b111);
    repeat (5) @(posedge clk);
    start_xfer(500, 3, 3'b001);
    wait_idle("t4b", 200);
    chk("t4_busy_start_ignored", n_accept - acc_before, 1);
    chk("t4_fires", d_fire, 20);
    v = (addr_log.size() > 0) ? addr_log[0] : -1;
    chk("t4_first_addr", v, 100);

    // 5: randomized transfers
    rdy_mode = 3;
    for (int k = 0; k < 8; k++) begin
      start_xfer($urandom_range(0, AMOD - 1), $urandom_range(1, 40), ND'($urandom));
      wait_idle("t5", 800);
    end

    // 6: reset in the middle of a transfer
    rdy_mode = 0;
    start_xfer(0, 25, 3'b111);
    v = 0;
    while (d_fire < 10 && v < 100) begin @(negedge clk); v++; end
    chk("t6_reach10_timeout", v < 100, 1);
    done_before = d_done;
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_busy",  busy, 0);
    chk("t6_rst_req",   read_req_glb_iact, 0);
    chk("t6_rst_en",    load_en_spad, 0);
    chk("t6_rst_done",  load_done, 0);
    chk("t6_rst_wdata", w_data_spad, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_done", d_done - done_before, 0);
    start_xfer(5, 6, 3'b101);
    wait_idle("t6", 100);
    chk("t6_fires", d_fire, 6);
    chk("t6_col1", col_cnt[1], 0);

`ifdef IACT_ZERO_FLAG_EN
    // 7: zero word at GLB[3]
    glb[3] = '0;
    start_xfer(0, 8, 3'b111);
    wait_idle("t7", 100);
    chk("t7_zero_cnt", d_zero, 1);
    chk("t7_zero_idx", zero_idx, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
